// File: rtl/digit_strip_ctrl.sv
// rtl/digit_strip_ctrl.sv - glyph ROM sequencer and pixel serialiser for a strip of digits
// Optional build macro: SCALE2_EN (double-size glyphs: 2x rows, 2x columns)
module digit_strip_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int GAP        = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_line_start,
    input  logic [9:0]              i_vcount,
    input  logic [9:0]              i_hcount,
    input  logic                    i_video_on,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_digits_in,
    output logic [3:0]              o_rom_digit,
    output logic [2:0]              o_rom_row,
    input  logic [4:0]              i_rom_code,
    output logic                    o_busy,
    output logic                    o_pixel_on
);

`ifdef SCALE2_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int              BAND_H     = 6 * SCALE;
    localparam int              PITCH_COLS = 5 + GAP;
    localparam int              CW         = $clog2(PITCH_COLS + 1);
    localparam logic [9:0]      Y0_V       = 10'(Y0);
    localparam logic [9:0]      X0_V       = 10'(X0);
    localparam logic [CW-1:0]   LAST_COL   = CW'(PITCH_COLS - 1);
    localparam logic [2:0]      LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]      NUM_V      = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CLEAR} state_t;

    state_t      r_state;
    state_t      w_next;

    // Storage is sized for the maximum strip so 3-bit indices are always in range
    logic [3:0]  r_digits  [8];
    logic [3:0]  r_shadow  [8];
    logic [4:0]  r_linebuf [8];
    logic        r_pending;
    logic [2:0]  r_fidx;
    logic [2:0]  r_row;

    logic [31:0] w_din_pad;
    logic [9:0]  w_vdiff;
    logic        w_in_band;
    logic [2:0]  w_row_calc;
    logic        w_fetch_start;
    logic        w_fetch_exit;
    logic [3:0]  w_cur_digit;

    assign w_din_pad     = 32'(i_digits_in);
    assign w_vdiff       = i_vcount - Y0_V;
    assign w_in_band     = (i_vcount >= Y0_V) && (w_vdiff < 10'(BAND_H));
`ifdef SCALE2_EN
    assign w_row_calc    = w_vdiff[3:1];
`else
    assign w_row_calc    = w_vdiff[2:0];
`endif
    assign w_fetch_start = i_line_start && w_in_band;
    assign w_fetch_exit  = (r_state == S_FETCH) && (w_next != S_FETCH);
    assign w_cur_digit   = r_digits[r_fidx];

    assign o_busy      = (r_state == S_FETCH);
    assign o_rom_digit = o_busy ? w_cur_digit : 4'd0;
    assign o_rom_row   = o_busy ? r_row : 3'd0;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state: line_start always wins so a new line restarts the fetch
    always_comb begin
        w_next = r_state;
        if (i_line_start) begin
            w_next = w_in_band ? S_FETCH : S_CLEAR;
        end else begin
            case (r_state)
                S_FETCH: if (r_fidx == LAST_IDX) w_next = S_IDLE;
                S_CLEAR: w_next = S_IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    // Fetch datapath: one glyph row per cycle into the line buffer, blank codes above 9
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fidx <= 3'd0;
            r_row  <= 3'd0;
            for (int k = 0; k < 8; k++) r_linebuf[k] <= 5'd0;
        end else begin
            if (r_state == S_FETCH)
                r_linebuf[r_fidx] <= (w_cur_digit > 4'd9) ? 5'd0 : i_rom_code;
            if (r_state == S_CLEAR)
                for (int k = 0; k < 8; k++) r_linebuf[k] <= 5'd0;
            if (w_fetch_start) begin
                r_fidx <= 3'd0;
                r_row  <= w_row_calc;
            end else if (r_state == S_FETCH) begin
                r_fidx <= r_fidx + 3'd1;
            end
        end
    end

    // Digit capture: loads during a fetch are shadowed and applied when the fetch ends
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_digits[k] <= 4'd0;
                r_shadow[k] <= 4'd0;
            end
        end else if (r_state != S_FETCH) begin
            if (i_load)
                for (int k = 0; k < 8; k++) r_digits[k] <= w_din_pad[4*k +: 4];
        end else if (w_fetch_exit) begin
            r_pending <= 1'b0;
            for (int k = 0; k < 8; k++)
                r_digits[k] <= i_load    ? w_din_pad[4*k +: 4] :
                               r_pending ? r_shadow[k] : r_digits[k];
        end else if (i_load) begin
            r_pending <= 1'b1;
            for (int k = 0; k < 8; k++) r_shadow[k] <= w_din_pad[4*k +: 4];
        end
    end

    // Serialiser: the first strip column restarts at hcount==X0, otherwise uses the running position
    logic          r_active;
    logic [CW-1:0] r_col;
    logic [3:0]    r_sidx;
    logic          w_start;
    logic          w_act;
    logic [CW-1:0] w_col;
    logic [3:0]    w_sidx;
    logic          w_adv;
    logic          w_wrap;
    logic [2:0]    w_bitsel;
    logic [4:0]    w_glyph;
    logic          w_pix;
`ifdef SCALE2_EN
    logic          r_sub;
    logic          w_sub;
`endif

    assign w_start  = i_video_on && (i_hcount == X0_V);
    assign w_act    = w_start || r_active;
    assign w_col    = w_start ? '0 : r_col;
    assign w_sidx   = w_start ? 4'd0 : r_sidx;
`ifdef SCALE2_EN
    assign w_sub    = w_start ? 1'b0 : r_sub;
    assign w_adv    = w_sub;
`else
    assign w_adv    = 1'b1;
`endif
    assign w_wrap   = w_adv && (w_col == LAST_COL);
    assign w_bitsel = 3'd4 - w_col[2:0];
    assign w_glyph  = r_linebuf[w_sidx[2:0]];
    assign w_pix    = w_act && i_video_on && (w_col < CW'(5)) && w_glyph[w_bitsel];

    // Serialiser state and registered pixel output
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pixel_on <= 1'b0;
            r_active   <= 1'b0;
            r_col      <= '0;
            r_sidx     <= 4'd0;
`ifdef SCALE2_EN
            r_sub      <= 1'b0;
`endif
        end else begin
            o_pixel_on <= w_pix;
            if (!i_video_on || !w_act) begin
                r_active <= 1'b0;
            end else begin
`ifdef SCALE2_EN
                r_sub <= ~w_sub;
`endif
                if (w_wrap) begin
                    r_col    <= '0;
                    r_sidx   <= w_sidx + 4'd1;
                    r_active <= (w_sidx + 4'd1) != NUM_V;
                end else begin
                    r_col    <= w_adv ? w_col + CW'(1) : w_col;
                    r_sidx   <= w_sidx;
                    r_active <= 1'b1;
                end
            end
        end
    end

endmodule
